bvudiv_sge_witness_checker: RTL and testbench
=============================================

// Module: bvudiv_sge_witness_checker
// PURPOSE
//  Sequential checker for Skolem witnesses of the 4-bit invertibility condition (x bvudiv s) bvsge t.
//  Per transaction it takes the operands (s, t) and a candidate witness x from a Skolem-function block.
//  - Recomputes x udiv s with a bit-serial restoring divider.
//  - Then exhaustively searches all x to decide whether any solution exists.
//  - Reports whether the witness is sound: a solution exists -> the witness must be one.
//  Sits downstream of the combinational Skolem netlists as their on-chip verifier.
// PARAMETERS
//  W  4  operand width (s, t, x, quotient); search space 2^W candidates
// PORTS
//  clk         in   1  clock, rising edge
//  rst_n       in   1  async active-low reset
//  in_valid    in   1  request valid
//  in_ready    out  1  request ready; high only in IDLE
//  s           in   W  divisor, unsigned
//  t           in   W  bound, two's-complement signed
//  x           in   W  witness under test, unsigned dividend
//  out_valid   out  1  result valid; held until out_ready
//  out_ready   in   1  result accepted
//  quotient    out  W  x udiv s; all-ones when s==0 (SMT-LIB)
//  witness_ok  out  1  quotient >=s t
//  exists      out  1  some x' in [0,2^W-1] satisfies the condition
//  found_x     out  W  smallest satisfying x' from search; x if witness_ok; 0 if !exists
//  skolem_ok   out  1  !exists | witness_ok
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - State -> IDLE, in_ready=1.
//   - out_valid, quotient, witness_ok, exists, found_x, skolem_ok = 0.
//   - Reset mid-transaction aborts it with no output.
//  FSM: IDLE -> DIV_WIT -> (SEARCH) -> DONE -> IDLE.
//  IDLE:
//   - in_valid & in_ready at cycle 0 registers s, t, x.
//   - Next state DIV_WIT.
//  Division step, one unit shared by witness and search:
//   - s!=0: W cycles, MSB first.
//     rem (W+1 bits) = {rem[W-1:0], dividend bit}.
//     If rem >= s: rem -= s, q bit = 1; else q bit = 0.
//   - s==0: 1 cycle, q = {W{1'b1}}.
//   - Result test: signed compare q >=s t, e.g. 4'hF = -1 and 4'h8 = -8.
//  DIV_WIT:
//   - Divides x.
//   - Pass: quotient=q, witness_ok=1, exists=1, found_x=x -> DONE.
//   - Fail: quotient=q, witness_ok=0 -> SEARCH with cand=0.
//  SEARCH:
//   - Divides cand, ascending.
//   - First pass -> exists=1, found_x=cand -> DONE.
//   - cand==2^W-1 fails -> exists=0, found_x=0 -> DONE.
//   - Otherwise cand+1, no wrap.
//  Latency:
//   - Witness pass: out_valid first high at cycle D+1, where D = W if s!=0, else 1.
//   - Otherwise cycle D + (k+1)*D + 1, k = index of last candidate tried.
//  DONE:
//   - out_valid=1; all outputs stable while out_valid & !out_ready.
//   - out_valid & out_ready -> IDLE next cycle; out_valid drops.
//   - in_ready=0 in every state except IDLE.
//   - in_valid outside IDLE is ignored; a new request is never accepted in the DONE-handshake cycle.
//  skolem_ok = !exists | witness_ok, registered with the other outputs.
// TESTING (W=4)
//  1. s=3,t=2,x=6 -> quotient=2, witness_ok=1, exists=1, found_x=6, skolem_ok=1, out_valid at cycle 5.
//  2. s=0,t=5,x=9 -> quotient=4'hF, witness_ok=0, 16 one-cycle candidates, exists=0, skolem_ok=1, out_valid at cycle 18.
//  3. s=1,t=7,x=3 -> witness_ok=0, search hits cand=7, exists=1, found_x=7, skolem_ok=0, out_valid at cycle 37.
//  4. s=2,t=4'h8,x=0 -> quotient=0 >=s -8, witness_ok=1, skolem_ok=1; then s=15,t=1,x=14 -> quotient=0, found_x=15, skolem_ok=0.
//  5. Backpressure:
//     - hold out_ready=0 for 5 cycles with in_valid=1 -> outputs stable, in_ready=0, no second capture;
//     - then out_ready=1 -> in_ready=1 next cycle.
//  6. Reset mid-SEARCH:
//     - rst_n=0 during test 3's search -> outputs 0, in_ready=1;
//     - rerun test 1 after release -> identical results and latency.

Source files
------------

// File: rtl/bvudiv_sge_witness_checker.sv
// Sequential verifier for Skolem witnesses of (x bvudiv s) bvsge t: divides the witness
// bit-serially, then searches every candidate x' in ascending order when the witness fails.
module bvudiv_sge_witness_checker #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] s,
    input  logic [W-1:0] t,
    input  logic [W-1:0] x,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] quotient,
    output logic         witness_ok,
    output logic         exists,
    output logic [W-1:0] found_x,
    output logic         skolem_ok
);

    // state   | meaning
    // IDLE    | waiting for a request, in_ready high
    // DIV_WIT | one load cycle, then dividing the witness x
    // SEARCH  | dividing candidate cand, ascending from 0
    // DONE    | result held until out_ready
    typedef enum logic [1:0] {IDLE, DIV_WIT, SEARCH, DONE} state_t;

    localparam int CW = (W > 2) ? $clog2(W) : 1;

    state_t state, state_nxt;

    logic [W-1:0]  s_r, t_r, x_r, cand, dvd;
    logic [W-1:0]  rem;
    logic [W-2:0]  q_part;
    logic [CW-1:0] cnt;
    logic          prep;

    logic [W:0]    r_shift;
    logic [W-1:0]  r_diff;
    logic          r_ge;
    logic [W-1:0]  q_step, q_fin;
    logic          last, pass;

    // One restoring-division step; the final step's quotient feeds the compare directly.
    always_comb begin
        r_shift = {rem, dvd[W-1]};
        r_ge    = (r_shift >= {1'b0, s_r});
        r_diff  = r_shift[W-1:0] - s_r;
        q_step  = {q_part, r_ge};
        last    = (s_r == '0) || (cnt == CW'(W-1));
        q_fin   = (s_r == '0) ? {W{1'b1}} : q_step;
        pass    = ($signed(q_fin) >= $signed(t_r));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = DIV_WIT;
            DIV_WIT: if (!prep && last) state_nxt = pass ? DONE : SEARCH;
            SEARCH:  if (last && (pass || cand == {W{1'b1}})) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_r        <= '0;
            t_r        <= '0;
            x_r        <= '0;
            cand       <= '0;
            dvd        <= '0;
            rem        <= '0;
            q_part     <= '0;
            cnt        <= '0;
            prep       <= 1'b0;
            quotient   <= '0;
            witness_ok <= 1'b0;
            exists     <= 1'b0;
            found_x    <= '0;
            skolem_ok  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        s_r  <= s;
                        t_r  <= t;
                        x_r  <= x;
                        prep <= 1'b1;
                    end
                end
                DIV_WIT: begin
                    if (prep) begin
                        rem    <= '0;
                        dvd    <= x_r;
                        q_part <= '0;
                        cnt    <= '0;
                        prep   <= 1'b0;
                    end else begin
                        rem    <= r_ge ? r_diff : r_shift[W-1:0];
                        dvd    <= {dvd[W-2:0], 1'b0};
                        q_part <= q_step[W-2:0];
                        cnt    <= cnt + CW'(1);
                        if (last) begin
                            quotient   <= q_fin;
                            witness_ok <= pass;
                            if (pass) begin
                                exists    <= 1'b1;
                                found_x   <= x_r;
                                skolem_ok <= 1'b1;
                            end else begin
                                cand   <= '0;
                                dvd    <= '0;
                                rem    <= '0;
                                q_part <= '0;
                                cnt    <= '0;
                            end
                        end
                    end
                end
                SEARCH: begin
                    rem    <= r_ge ? r_diff : r_shift[W-1:0];
                    dvd    <= {dvd[W-2:0], 1'b0};
                    q_part <= q_step[W-2:0];
                    cnt    <= cnt + CW'(1);
                    if (last) begin
                        if (pass) begin
                            exists    <= 1'b1;
                            found_x   <= cand;
                            skolem_ok <= 1'b0;
                        end else if (cand == {W{1'b1}}) begin
                            exists    <= 1'b0;
                            found_x   <= '0;
                            skolem_ok <= 1'b1;
                        end else begin
                            cand   <= cand + W'(1);
                            dvd    <= cand + W'(1);
                            rem    <= '0;
                            q_part <= '0;
                            cnt    <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bvudiv_sge_witness_checker.sv
// Randomized and directed bench for bvudiv_sge_witness_checker against a plain-arithmetic
// model of the witness check, the exhaustive search and the latency formula.
module tb_bvudiv_sge_witness_checker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] s = '0, t = '0, x = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] quotient;
    logic       witness_ok, exists, skolem_ok;
    logic [3:0] found_x;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    typedef struct {
        logic [3:0] q;
        logic       wok;
        logic       ex;
        logic [3:0] fx;
        logic       sk;
        int         lat;
    } exp_t;

    exp_t exp_r;

    bvudiv_sge_witness_checker #(.W(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .s(s), .t(t), .x(x), .out_valid(out_valid), .out_ready(out_ready),
        .quotient(quotient), .witness_ok(witness_ok), .exists(exists),
        .found_x(found_x), .skolem_ok(skolem_ok)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [3:0] udiv(input int a, input int b);
        if (b == 0) return 4'hF;
        return 4'(a / b);
    endfunction

    function automatic logic sge(input logic [3:0] a, input logic [3:0] b);
        int sa, sb;
        sa = (a > 7) ? int'(a) - 16 : int'(a);
        sb = (b > 7) ? int'(b) - 16 : int'(b);
        return sa >= sb;
    endfunction

    function automatic exp_t model(input int ss, input logic [3:0] tt, input int xx);
        exp_t e;
        int d, k;
        d = (ss == 0) ? 1 : 4;
        e.q = udiv(xx, ss);
        e.wok = sge(e.q, tt);
        if (e.wok) begin
            e.ex = 1'b1; e.fx = 4'(xx); e.sk = 1'b1; e.lat = d + 1;
        end else begin
            e.ex = 1'b0; e.fx = 4'h0; e.sk = 1'b1;
            k = 15;
            for (int c = 15; c >= 0; c--)
                if (sge(udiv(c, ss), tt)) k = c;
            if (sge(udiv(k, ss), tt)) begin
                e.ex = 1'b1; e.fx = 4'(k); e.sk = 1'b0;
            end
            e.lat = d + (k + 1) * d + 1;
        end
        return e;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Every cycle a result is presented it must match the model.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            chk("quotient", quotient, exp_r.q);
            chk("witness_ok", witness_ok, exp_r.wok);
            chk("exists", exists, exp_r.ex);
            chk("found_x", found_x, exp_r.fx);
            chk("skolem_ok", skolem_ok, exp_r.sk);
            chk("in_ready_in_done", in_ready, 0);
        end
    end

    task automatic run_txn(input logic [3:0] ss, input logic [3:0] tt, input logic [3:0] xx,
                           input int hold, input bit busy_in);
        int c0, n;
        @(negedge clk);
        chk("in_ready_idle", in_ready, 1);
        exp_r = model(ss, tt, xx);
        s = ss; t = tt; x = xx; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        c0 = cyc;
        n = 0;
        while (!out_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) begin
            n_cmp++; n_err++;
            $display("FAIL timeout: out_valid never rose for s=%0d t=%0d x=%0d", ss, tt, xx);
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            return;
        end
        chk("latency", cyc - c0, exp_r.lat);
        if (busy_in) begin
            in_valid = 1'b1; s = ~ss; t = ~tt; x = ~xx;
        end
        repeat (hold) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b0;
        chk("out_valid_drop", out_valid, 0);
        chk("in_ready_after", in_ready, 1);
    endtask

    initial begin
        exp_t m;
        m = model(3, 4'd2, 6);
        chk("pin1_q", m.q, 2);
        chk("pin1_lat", m.lat, 5);
        m = model(0, 4'd5, 9);
        chk("pin2_ex", m.ex, 0);
        chk("pin2_lat", m.lat, 18);
        m = model(1, 4'd7, 3);
        chk("pin3_fx", m.fx, 7);
        chk("pin3_sk", m.sk, 0);
        chk("pin3_lat", m.lat, 37);
        m = model(15, 4'd1, 14);
        chk("pin4_fx", m.fx, 15);
        m = model(2, 4'h8, 0);
        chk("pin4_wok", m.wok, 1);

        #12;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_quotient", quotient, 0);
        chk("rst_skolem_ok", skolem_ok, 0);
        rst_n = 1'b1;

        run_txn(4'd3, 4'd2, 4'd6, 0, 0);
        run_txn(4'd0, 4'd5, 4'd9, 1, 0);
        run_txn(4'd1, 4'd7, 4'd3, 0, 0);
        run_txn(4'd2, 4'h8, 4'd0, 0, 0);
        run_txn(4'd15, 4'd1, 4'd14, 0, 0);
        run_txn(4'd3, 4'd2, 4'd6, 5, 1);

        // Reset in the middle of the search of s=1,t=7,x=3.
        @(negedge clk);
        exp_r = model(1, 4'd7, 3);
        s = 4'd1; t = 4'd7; x = 4'd3; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (15) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_exists", exists, 0);
        chk("midrst_found_x", found_x, 0);
        chk("midrst_witness_ok", witness_ok, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_txn(4'd3, 4'd2, 4'd6, 0, 0);

        for (int i = 0; i < 60; i++)
            run_txn(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                    4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 1) == 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
